// File: rtl/regfile_mp_if.sv
// Bus bundle between the pipeline and regfile_mp.
//   master : decode/writeback side, drives read addresses, write requests and clr_req
//   slave  : the register file, returns rd_data and ready
// Signals:
//   clr_req  request a full clear (single-cycle pulse)
//   ready    1 = file usable, 0 while the clear engine runs
//   rd_addr  NUM_RD packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data  NUM_RD packed read data, port p at [p*DATA_W +: DATA_W]
//   wr_en    per-port write enable
//   wr_addr  NUM_WR packed write addresses
//   wr_data  NUM_WR packed write data
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic                       clr_req;
  logic                       ready;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_WR-1:0]          wr_en;
  logic [NUM_WR*ADDR_W-1:0]   wr_addr;
  logic [NUM_WR*DATA_W-1:0]   wr_data;

  modport master (
    output clr_req, rd_addr, wr_en, wr_addr, wr_data,
    input  ready, rd_data
  );

  modport slave (
    input  clr_req, rd_addr, wr_en, wr_addr, wr_data,
    output ready, rd_data
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with NUM_RD combinational read ports and NUM_WR
// write ports. Optional hardwired-zero entry 0 and same-cycle write-to-read
// bypass. Contents are zeroed by a sequential clear engine (one entry per
// cycle) that runs after reset and on clr_req, instead of a wide reset.
// Ports:
//   clk  clock, all state updates on the rising edge
//   rst  asynchronous, active-low reset
//   bus  regfile_mp_if.slave (clr_req, ready, rd_*, wr_*)
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic        clk,
  input  logic        rst,
  regfile_mp_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_idx;
  logic                ready_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Unpacked views of the flat bus vectors.
  logic [ADDR_W-1:0]   rd_a   [NUM_RD];
  logic [ADDR_W-1:0]   wr_a   [NUM_WR];
  logic [DATA_W-1:0]   wr_d   [NUM_WR];
  logic [NUM_WR-1:0]   wr_ok;
  logic [DATA_W-1:0]   rd_val [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rd_flat;

  // A write is effective only when enabled and not aimed at the hardwired zero entry.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ok = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      wr_a[w]  = bus.wr_addr[w*ADDR_W +: ADDR_W];
      wr_d[w]  = bus.wr_data[w*DATA_W +: DATA_W];
      wr_ok[w] = bus.wr_en[w] && !((ZERO_REG != 0) && (wr_a[w] == '0));
    end
    for (int p = 0; p < NUM_RD; p++) begin
      rd_a[p] = bus.rd_addr[p*ADDR_W +: ADDR_W];
    end
  end

  // Clear engine: CLEAR walks clr_idx over every entry, READY serves traffic.
  // ready is registered and rises together with the CLEAR->READY transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
      ready_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + ADDR_W'(1);
          if (clr_idx == ADDR_W'(DEPTH - 1)) begin
            state   <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: begin
          if (bus.clr_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_idx <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage. Writes in the clr_req cycle still land; the clear that follows wipes them.
  // Ports are applied in ascending order, so on an address conflict the
  // highest-index port's assignment is the one that sticks.
  // NOTE: the array has no reset term; the clear engine zeroes it, keeping it mappable to RAM.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w]) begin
          mem[wr_a[w]] <= wr_d[w];
        end
      end
    end
  end

  // Combinational reads with optional forwarding of this cycle's write data.
  always_comb begin
    rd_flat = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_val[p] = mem[rd_a[p]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NUM_WR; w++) begin
          if (wr_ok[w] && (wr_a[w] == rd_a[p])) begin
            rd_val[p] = wr_d[w];
          end
        end
      end
      if ((ZERO_REG != 0) && (rd_a[p] == '0)) begin
        rd_val[p] = '0;
      end
      if (!ready_q) begin
        rd_val[p] = '0;
      end
      rd_flat[p*DATA_W +: DATA_W] = rd_val[p];
    end
  end

  assign bus.rd_data = rd_flat;
  assign bus.ready   = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters).
// Directed vector table, hand-written clear/reset sequences, and a random
// phase compared against a behavioural model of the register file.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk;
  logic rst;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(2)) bus ();

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus variables feeding the interface.
  logic [AW-1:0] ra [2];
  logic [AW-1:0] wa [2];
  logic [DW-1:0] wd [2];
  logic [1:0]    we;
  logic          clr_req;

  assign bus.rd_addr = {ra[1], ra[0]};
  assign bus.wr_addr = {wa[1], wa[0]};
  assign bus.wr_data = {wd[1], wd[0]};
  assign bus.wr_en   = we;
  assign bus.clr_req = clr_req;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: contents, usability flag, and remaining clear cycles.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_ready;
  int            m_clear_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Effect of one rising edge on the model (only called while rst is high).
  task automatic model_edge();
    if (m_clear_left > 0) begin
      m_clear_left--;
      if (m_clear_left == 0) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_ready = 1'b1;
      end
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (we[w] && wa[w] != 0) m_mem[wa[w]] = wd[w];
      end
      if (clr_req) begin
        m_clear_left = DEPTH;
        m_ready      = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] exp_rd(input int p);
    logic [31:0] r;
    if (!m_ready) return '0;
    if (ra[p] == 0) return '0;
    r = m_mem[ra[p]];
    for (int w = 0; w < 2; w++) begin
      if (we[w] && wa[w] == ra[p]) r = wd[w];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_ready"}, 32'(bus.ready), 32'(m_ready));
    check({tag, "_rd0"}, bus.rd_data[31:0],  exp_rd(0));
    check({tag, "_rd1"}, bus.rd_data[63:32], exp_rd(1));
  endtask

  task automatic idle_inputs();
    we = '0; wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
    ra[0] = '0; ra[1] = '0; clr_req = 1'b0;
  endtask

  // Reads every address on both ports with no writes; all must be zero.
  task automatic sweep_zero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      we = '0; ra[0] = AW'(a); ra[1] = AW'(DEPTH - 1 - a);
      #1;
      check($sformatf("%s_a%0d_p0", tag, a), bus.rd_data[31:0],  32'h0);
      check($sformatf("%s_a%0d_p1", tag, a), bus.rd_data[63:32], 32'h0);
      tick();
    end
  endtask

  // Counts cycles until ready rises, with ignored writes hammering the file.
  task automatic count_clear(input string tag);
    int cnt = 0;
    while (!bus.ready && cnt < 100) begin
      we = 2'b11;
      wa[0] = AW'($urandom_range(1, DEPTH - 1)); wa[1] = AW'($urandom_range(1, DEPTH - 1));
      wd[0] = $urandom | 32'h1; wd[1] = $urandom | 32'h1;
      ra[0] = wa[0]; ra[1] = wa[1];
      #1;
      check({tag, "_rd0_zero"}, bus.rd_data[31:0],  32'h0);
      check({tag, "_rd1_zero"}, bus.rd_data[63:32], 32'h0);
      tick();
      cnt++;
    end
    check({tag, "_ready_len"}, 32'(cnt), 32'd32);
    idle_inputs();
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Directed vectors: expected values are same-cycle reads (bypass visible).
    vecs[0] = '{2'b01, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        5'd5,  5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd5,  5'd0, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{2'b11, 5'd7,  5'd7,  32'h11,       32'h22,       5'd7,  5'd7, 32'h22,       32'h22};
    vecs[3] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd7,  5'd5, 32'h22,       32'hDEADBEEF};
    vecs[4] = '{2'b10, 5'd0,  5'd0,  32'h0,        32'hFFFFFFFF, 5'd0,  5'd0, 32'h0,        32'h0};
    vecs[5] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd0,  5'd7, 32'h0,        32'h22};
    vecs[6] = '{2'b11, 5'd9,  5'd10, 32'hAAAA5555, 32'h12345678, 5'd10, 5'd9, 32'h12345678, 32'hAAAA5555};
    vecs[7] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        5'd9,  5'd10, 32'hAAAA5555, 32'h12345678};

    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_ready = 1'b0;
    m_clear_left = DEPTH;
    rst = 1'b0;
    idle_inputs();

    // Reset state.
    #2;
    check("reset_ready", 32'(bus.ready), 32'h0);
    check("reset_rd0", bus.rd_data[31:0], 32'h0);

    // Reset release: ready low for exactly 32 cycles, then everything reads 0.
    @(posedge clk); #1;
    rst = 1'b1;
    count_clear("rst_release");
    sweep_zero("post_reset");

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      we = vecs[i].we; wa[0] = vecs[i].wa0; wa[1] = vecs[i].wa1;
      wd[0] = vecs[i].wd0; wd[1] = vecs[i].wd1;
      ra[0] = vecs[i].ra0; ra[1] = vecs[i].ra1; clr_req = 1'b0;
      #1;
      check($sformatf("vec%0d_rd0", i), bus.rd_data[31:0],  vecs[i].e0);
      check($sformatf("vec%0d_rd1", i), bus.rd_data[63:32], vecs[i].e1);
      tick();
    end
    idle_inputs();

    // clr_req: fill 1..31, pulse clear (with writes in that cycle), expect full wipe.
    for (int a = 1; a < DEPTH; a++) begin
      we = 2'b01; wa[0] = AW'(a); wd[0] = 32'hA5000000 | 32'(a);
      tick();
    end
    we = '0; ra[0] = 5'd31; ra[1] = 5'd1;
    #1;
    check("fill_rd31", bus.rd_data[31:0],  32'hA500001F);
    check("fill_rd1",  bus.rd_data[63:32], 32'hA5000001);
    clr_req = 1'b1; we = 2'b11; wa[0] = 5'd3; wa[1] = 5'd4; wd[0] = 32'h3333; wd[1] = 32'h4444;
    tick();
    clr_req = 1'b0;
    check("clr_ready_drop", 32'(bus.ready), 32'h0);
    count_clear("clr_req");
    sweep_zero("post_clr");

    // Randomised traffic against the model, including occasional clears.
    for (int i = 0; i < 400; i++) begin
      we = 2'($urandom);
      for (int w = 0; w < 2; w++) begin
        wa[w] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom);
        wd[w] = $urandom;
      end
      for (int p = 0; p < 2; p++) begin
        ra[p] = ($urandom_range(0, 1) == 1) ? wa[$urandom_range(0, 1)] : AW'($urandom);
      end
      clr_req = ($urandom_range(0, 99) == 0);
      #1;
      check_model($sformatf("rand%0d", i));
      tick();
    end
    idle_inputs();

    // Make sure the file holds data, then reset in the middle of a clear.
    while (!m_ready) tick();
    for (int a = 1; a < DEPTH; a++) begin
      we = 2'b01; wa[0] = AW'(a); wd[0] = ~32'(a);
      tick();
    end
    idle_inputs();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b0;
    m_clear_left = DEPTH;
    m_ready = 1'b0;
    #1;
    check("midclr_rst_ready", 32'(bus.ready), 32'h0);
    tick();
    tick();
    rst = 1'b1;
    count_clear("midclr_release");
    sweep_zero("post_midclr");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
